// File: rtl/npu_pkg.sv
// npu_pkg: state encoding, result sizing and default limits shared by the tile scheduler.
package npu_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, WAIT, RESULT} state_t;
    localparam int TIMEOUT_DEF = 64;
    function automatic int res_width(input int dw, input int rows, input int cols);
        return 4 * dw * (rows + cols - 1);
    endfunction
endpackage

// File: rtl/npu_tile_sched_addr_gen.sv
// npu_addr_gen: loadable operand address/beat counter; flags the final read beat.
module npu_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  last
);
    logic [LEN_WIDTH-1:0] rem;
    assign last = rd_en && rem == '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rem     <= '0;
        end else if (load) begin
            rd_en   <= 1'b1;
            rd_addr <= base;
            rem     <= len - 1'b1;
        end else if (rd_en) begin
            rd_en <= rem != '0;
            if (rem != '0) begin
                rd_addr <= rd_addr + 1'b1;
                rem     <= rem - 1'b1;
            end
        end
    end
endmodule

// File: rtl/npu_tile_sched.sv
// npu_tile_sched: runs one systolic tile per host command and returns the edge psums.
// NPU_TILE_PERF_EN adds perf_cycles/perf_tiles counters.
module npu_tile_sched
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAT_ROWS   = 3,
    parameter int MAT_COLS   = 3,
    parameter int ARR_DIM    = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cmd_valid,
    output logic                                                cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                               cmd_base_addr,
    input  logic [LEN_WIDTH-1:0]                                cmd_len,
    output logic                                                op_rd_en,
    output logic [ADDR_WIDTH-1:0]                               op_rd_addr,
    input  logic [DATA_WIDTH*ARR_DIM-1:0]                       op_a_data,
    input  logic [DATA_WIDTH*ARR_DIM-1:0]                       op_b_data,
    output logic                                                arr_start,
    output logic                                                arr_in_valid,
    output logic                                                arr_w_valid,
    output logic                                                arr_in_done,
    output logic                                                arr_w_done,
    output logic [DATA_WIDTH*ARR_DIM-1:0]                       arr_a_vec,
    output logic [DATA_WIDTH*ARR_DIM-1:0]                       arr_b_vec,
    input  logic                                                arr_done,
    input  logic [res_width(DATA_WIDTH, MAT_ROWS, MAT_COLS)-1:0] arr_c_vec,
    output logic                                                res_valid,
    input  logic                                                res_ready,
    output logic [res_width(DATA_WIDTH, MAT_ROWS, MAT_COLS)-1:0] res_data,
    output logic                                                res_err,
    output logic                                                busy
`ifdef NPU_TILE_PERF_EN
    ,
    output logic [31:0]                                         perf_cycles,
    output logic [15:0]                                         perf_tiles
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic accept, zero, last, tmo, vld, done_p;
    assign accept       = cmd_valid && state == IDLE;
    assign zero         = cmd_len == '0;
    // Abort on the edge where the counter would reach TIMEOUT.
    assign tmo          = tcnt == TW'(TIMEOUT - 1);
    assign cmd_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign res_valid    = state == RESULT;
    assign arr_in_valid = vld;
    assign arr_w_valid  = vld;
    assign arr_in_done  = done_p;
    assign arr_w_done   = done_p;
    assign arr_a_vec    = op_a_data;
    assign arr_b_vec    = op_b_data;

    npu_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_addr (
        .clk(clk), .rst(rst), .load(accept && !zero), .base(cmd_base_addr), .len(cmd_len),
        .rd_en(op_rd_en), .rd_addr(op_rd_addr), .last(last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = zero ? RESULT : LOAD;
            LOAD:    if (last) state_n = DRAIN;
            DRAIN:   state_n = WAIT;
            WAIT:    if (arr_done || tmo) state_n = RESULT;
            RESULT:  if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= 1'b0;
            done_p    <= 1'b0;
            tcnt      <= '0;
            arr_start <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
        end else begin
            vld    <= op_rd_en;
            done_p <= state == DRAIN;
            tcnt   <= state == WAIT ? tcnt + 1'b1 : '0;
            if (accept) arr_start <= !zero;
            else if (state == WAIT && (arr_done || tmo)) arr_start <= 1'b0;
            if (accept && zero) res_err <= 1'b1;
            else if (state == WAIT && arr_done) begin
                res_err  <= 1'b0;
                res_data <= arr_c_vec;
            end else if (state == WAIT && tmo) res_err <= 1'b1;
        end
    end

`ifdef NPU_TILE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_tiles  <= '0;
        end else begin
            if (accept) perf_cycles <= 32'd1;
            else if ((state == LOAD || state == DRAIN || state == WAIT) && perf_cycles != '1)
                perf_cycles <= perf_cycles + 1'b1;
            if (res_valid && res_ready && !res_err) perf_tiles <= perf_tiles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_npu_tile_sched.sv
// tb_npu_tile_sched: directed table plus random tiles against a per-tile timing model.
module tb_npu_tile_sched;
    import npu_pkg::*;
    localparam int DW = 8, AD = 5, AW = 8, LW = 8, TO = 64;
    localparam int VW = DW * AD;
    localparam int RW = res_width(DW, 3, 3);

    logic clk = 0, rst = 0;
    logic cmd_valid = 0, cmd_ready;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic op_rd_en;
    logic [AW-1:0] op_rd_addr;
    logic [VW-1:0] op_a_data = '0, op_b_data = '0, arr_a_vec, arr_b_vec;
    logic arr_start, arr_in_valid, arr_w_valid, arr_in_done, arr_w_done;
    logic arr_done = 0;
    logic [RW-1:0] arr_c_vec = '0, res_data;
    logic res_valid, res_ready = 0, res_err, busy;
`ifdef NPU_TILE_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_tiles;
`endif

    always #5 clk = ~clk;

    npu_tile_sched #(.DATA_WIDTH(DW), .MAT_ROWS(3), .MAT_COLS(3), .ARR_DIM(AD),
                     .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len), .op_rd_en(op_rd_en),
        .op_rd_addr(op_rd_addr), .op_a_data(op_a_data), .op_b_data(op_b_data),
        .arr_start(arr_start), .arr_in_valid(arr_in_valid), .arr_w_valid(arr_w_valid),
        .arr_in_done(arr_in_done), .arr_w_done(arr_w_done), .arr_a_vec(arr_a_vec),
        .arr_b_vec(arr_b_vec), .arr_done(arr_done), .arr_c_vec(arr_c_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
`ifdef NPU_TILE_PERF_EN
        , .perf_cycles(perf_cycles), .perf_tiles(perf_tiles)
`endif
    );

    int checks = 0, errors = 0;
    logic [RW-1:0] last_res = '0;
    int exp_tiles = 0;

    typedef struct {
        logic [7:0] base;
        int len;
        int dly;
        int rdy;
        bit err;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rnd_vec();
        logic [RW-1:0] v;
        for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // dly < 0: array never signals done; dly counts cycles after WAIT entry.
    task automatic run_tile(input logic [7:0] base, input int len, input int dly,
                            input int rdy, input bit exp_err, input bit noise);
        int k, resk, wentry, nrd, nval, vfirst, ndone, dk, nstart, fin, exp_resk;
        bit addr_ok, pass_ok, wmatch, stable;
        logic [RW-1:0] done_vec, exp_data;
        k = 1; resk = -1; wentry = -1; nrd = 0; nval = 0; vfirst = 0; ndone = 0; dk = 0;
        nstart = 0; addr_ok = 1; pass_ok = 1; wmatch = 1; stable = 1; done_vec = '0;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_base_addr = base; cmd_len = len[7:0];
        @(negedge clk);
        cmd_valid = 0;
        while (resk < 0 && k < 600) begin
            if (op_rd_en) begin
                if (op_rd_addr !== 8'(base + nrd)) addr_ok = 0;
                nrd++;
            end
            if (arr_in_valid) begin
                if (nval == 0) vfirst = k;
                nval++;
            end
            if (arr_in_valid !== arr_w_valid || arr_in_done !== arr_w_done) wmatch = 0;
            if (arr_in_done) begin
                ndone++; dk = k; wentry = k;
            end
            if (arr_start) nstart++;
            if (arr_a_vec !== op_a_data || arr_b_vec !== op_b_data) pass_ok = 0;
            if (res_valid) resk = k;
            else begin
                op_a_data = VW'(rnd_vec()); op_b_data = VW'(rnd_vec());
                arr_c_vec = rnd_vec();
                arr_done = (wentry >= 0) ? (dly >= 0 && k == wentry + dly)
                                         : (noise && $urandom_range(0, 3) == 0);
                if (arr_done && wentry >= 0) done_vec = arr_c_vec;
                @(negedge clk);
                k++;
            end
        end
        arr_done = 0;
        if (len == 0) exp_resk = 1;
        else begin
            fin = (dly >= 0 && dly <= TO - 1) ? len + 2 + dly : len + 2 + TO - 1;
            exp_resk = fin + 1;
        end
        exp_data = (len != 0 && dly >= 0 && dly <= TO - 1) ? done_vec : last_res;
        chk("res_cycle", resk, exp_resk);
        chk("res_err", res_err, exp_err);
        chk("res_data", res_data, exp_data);
        chk("rd_count", nrd, len);
        chk("rd_addr_seq", addr_ok, 1);
        chk("valid_count", nval, len);
        chk("valid_first", vfirst, len != 0 ? 2 : 0);
        chk("done_pulses", ndone, len != 0 ? 1 : 0);
        chk("done_cycle", dk, len != 0 ? len + 2 : 0);
        chk("start_cycles", nstart, exp_resk - 1);
        chk("start_in_result", arr_start, 0);
        chk("pass_through", pass_ok, 1);
        chk("w_matches_in", wmatch, 1);
`ifdef NPU_TILE_PERF_EN
        chk("perf_cycles", perf_cycles, exp_resk);
`endif
        if (rdy > 0) begin
            cmd_valid = 1; cmd_len = 8'd1;
            repeat (rdy) begin
                @(negedge clk);
                if (!res_valid || res_data !== exp_data || res_err !== exp_err || cmd_ready) stable = 0;
            end
            chk("backpressure_stable", stable, 1);
        end
        cmd_valid = 0; res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("res_consumed", res_valid, 0);
        chk("idle_after_result", {busy, cmd_ready}, 2'b01);
        last_res = exp_data;
        if (!exp_err) exp_tiles++;
`ifdef NPU_TILE_PERF_EN
        chk("perf_tiles", perf_tiles, exp_tiles);
`endif
    endtask

    initial begin
        tbl[0] = '{8'h10, 5, 8, 0, 0};
        tbl[1] = '{8'h33, 0, 0, 0, 1};
        tbl[2] = '{8'h20, 3, -1, 0, 1};
        tbl[3] = '{8'hFE, 4, 3, 10, 0};
        tbl[4] = '{8'h40, 2, 63, 1, 0};
        tbl[5] = '{8'h50, 1, 0, 2, 0};
        tbl[6] = '{8'hF0, 255, 2, 0, 0};
        #1;
        chk("reset_outputs", {busy, op_rd_en, arr_start, arr_in_valid, arr_in_done, res_valid,
                              res_err, op_rd_addr}, '0);
        chk("reset_res_data", res_data, '0);
        chk("reset_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1;
        foreach (tbl[i]) run_tile(tbl[i].base, tbl[i].len, tbl[i].dly, tbl[i].rdy, tbl[i].err, 0);
        for (int i = 0; i < 20; i++) begin
            int len, dly;
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 40);
            run_tile(8'($urandom), len, dly, $urandom_range(0, 3), len == 0 || dly < 0, 1);
        end
        @(negedge clk);
        cmd_valid = 1; cmd_base_addr = 8'h80; cmd_len = 8'd6;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        chk("mid_load_addr", op_rd_addr, 8'h81);
        rst = 0;
        #1;
        chk("async_reset_outputs", {busy, op_rd_en, arr_start, arr_in_valid, arr_in_done,
                                    res_valid, res_err, op_rd_addr}, '0);
        chk("async_reset_res_data", res_data, '0);
        last_res = '0;
        exp_tiles = 0;
`ifdef NPU_TILE_PERF_EN
        chk("reset_perf", {perf_cycles, perf_tiles}, '0);
`endif
        @(negedge clk);
        rst = 1;
        run_tile(8'h05, 3, 4, 0, 0, 0);
        run_tile(8'h09, 0, 0, 0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/npu_tile_sched.md
Name: npu_tile_sched

Overview:
- Sequencer that runs one systolic tile on the NPU MAC array per host command.
- Accepts a command (operand base address, beat count) and reads skewed A/B operand vectors from the operand buffer.
- Streams those vectors into the array with start/valid/done signalling, waits for the array's done pulse, then captures the edge feature-map vector and returns it to the host over a valid/ready handshake.
- Sits between the host/DMA command interface, the operand buffer and the MAC array.

Parameters:
- DATA_WIDTH, 8: operand element width.
- MAT_ROWS, 3: output matrix rows.
- MAT_COLS, 3: output matrix columns.
- ARR_DIM, 5: array side length; must equal BASE_LENGTH + max(MAT_ROWS, MAT_COLS) - 1 of the array.
- ADDR_WIDTH, 8: operand buffer address width.
- LEN_WIDTH, 8: beat-count width.
- TIMEOUT, 64: maximum WAIT cycles before the tile is aborted.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_base_addr  in  ADDR_WIDTH  first operand address.
- cmd_len  in  LEN_WIDTH  number of operand beats.
- op_rd_en  out  1  operand buffer read strobe.
- op_rd_addr  out  ADDR_WIDTH  operand buffer address.
- op_a_data  in  DATA_WIDTH*ARR_DIM  activation vector; valid 1 cycle after the read.
- op_b_data  in  DATA_WIDTH*ARR_DIM  weight vector; valid 1 cycle after the read.
- arr_start  out  1  array start.
- arr_in_valid  out  1  activation valid.
- arr_w_valid  out  1  weight valid.
- arr_in_done  out  1  activation done pulse.
- arr_w_done  out  1  weight done pulse.
- arr_a_vec  out  DATA_WIDTH*ARR_DIM  combinational pass-through of op_a_data.
- arr_b_vec  out  DATA_WIDTH*ARR_DIM  combinational pass-through of op_b_data.
- arr_done  in  1  array completion pulse.
- arr_c_vec  in  32*DATA_WIDTH/8*(MAT_ROWS+MAT_COLS-1) (= 4*DATA_WIDTH*(MAT_ROWS+MAT_COLS-1))  array edge psums.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts result.
- res_data  out  same width as arr_c_vec  captured result.
- res_err  out  1  result invalid (zero length or timeout).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all registered outputs 0, including res_data, res_err, op_rd_addr, beat and timeout counters. cmd_ready is 1 once in IDLE. A reset mid-tile abandons the tile; no done pulses are emitted.
- States are IDLE, LOAD, DRAIN, WAIT, RESULT.
- IDLE: on cmd_valid&&cmd_ready at edge T, latch base and len. If len==0, go to RESULT with res_err=1 and no array activity. Otherwise go to LOAD.
- LOAD (cycles T+1..T+len):
  - op_rd_en=1; op_rd_addr = base+i, i = 0..len-1, wrapping modulo 2^ADDR_WIDTH.
  - arr_start=1 from T+1.
  - arr_in_valid and arr_w_valid are a 1-cycle registered copy of op_rd_en, so they are high T+2..T+len+1, aligned with the read data.
  - After the last read, go to DRAIN.
- DRAIN (one cycle, T+len+1): last beat valid. At T+len+2, arr_in_done and arr_w_done pulse high for exactly one cycle, both together, and the FSM enters WAIT.
- WAIT:
  - arr_start held high.
  - The timeout counter starts at 0 on WAIT entry and increments each cycle.
  - On arr_done: capture arr_c_vec into res_data, set res_err=0, drop arr_start, go to RESULT.
  - If the counter reaches TIMEOUT without arr_done: res_err=1, res_data unchanged, drop arr_start, go to RESULT.
  - If arr_done and timeout coincide, done wins.
- arr_done outside WAIT is ignored.
- RESULT:
  - res_valid=1; res_data and res_err held stable until res_valid&&res_ready, then return to IDLE.
  - arr_start stays 0 for at least one cycle, so the array clears its internal letting flag before the next tile.
  - A new cmd is accepted no earlier than the cycle after the result is consumed.
- cmd_len=2^LEN_WIDTH-1 is legal; address wrap is not an error.

Optional Feature:
- Macro: NPU_TILE_PERF_EN.
- Defined: adds output perf_cycles (32 bits), reset 0. It counts cycles from cmd accept through arr_done capture (or timeout), saturating at all-ones, and is held from RESULT entry until the next accept. It also adds output perf_tiles (16 bits), which increments on every res handshake where res_err=0 and wraps at the top.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Package npu_pkg holds:
  - the state enum: IDLE, LOAD, DRAIN, WAIT, RESULT;
  - a localparam function for the result width, 4*DATA_WIDTH*(MAT_ROWS+MAT_COLS-1);
  - the default TIMEOUT constant.
- One sub-module, npu_addr_gen: loadable address/beat counter that outputs op_rd_addr, op_rd_en and a last-beat flag.

Test Plan:
- Nominal tile: base=0x10, len=5, array pulses done 8 cycles after in_done → reads 0x10..0x14; in_valid high 5 cycles; in_done and w_done single pulses together; res_data equals arr_c_vec; res_err=0.
- Zero length: len=0 → no op_rd_en and no arr_start; res_valid next cycle with res_err=1.
- Timeout: TIMEOUT=64, arr_done never asserted → res_err=1 exactly 64 cycles after WAIT entry; arr_start low in RESULT.
- Backpressure and wrap: base=0xFE, len=4 → addresses FE, FF, 00, 01; res_ready held low 10 cycles → res_data stable and cmd_ready=0 throughout.
- Reset mid-LOAD: rst low at beat 2 → all outputs 0 asynchronously; after release, a new command runs a clean tile.
- PERF (macro defined): nominal tile → perf_cycles = len+2+8+1 = 16 with done 8 cycles after WAIT entry; perf_tiles increments 0→1.
